// File: rtl/riscv_defs.sv
// Shared RISC-V core definitions: memory geometry, instruction widths and the
// fetch-stage state encoding.
package riscv_defs;

    localparam int NB_BYTE  = 8;
    localparam int MEM_SIZE = 1024;

    typedef logic [NB_BYTE-1:0] mem_t [MEM_SIZE];

    localparam int NB_ADDR  = 32;
    localparam int NB_INSTR = 32;

    // addi x0, x0, 0
    localparam logic [NB_INSTR-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/imem_if.sv
// Instruction memory port: the CPU presents an address, the memory answers
// combinationally in the same cycle.
interface imem_if;
    import riscv_defs::*;

    logic [NB_ADDR-1:0]  imem_pc;
    logic [NB_INSTR-1:0] imem_instruction;

    modport cpu (output imem_pc, input imem_instruction);
    modport mem (input imem_pc, output imem_instruction);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Reset beats everything; a flush bubbles the slot
// with a NOP, a kill only drops the valid bit, load captures a new fetch and
// otherwise the contents hold.
module if_id_reg
    import riscv_defs::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                flush,
    input  logic                kill,
    input  logic [NB_ADDR-1:0]  pc_in,
    input  logic [NB_ADDR-1:0]  pc4_in,
    input  logic [NB_INSTR-1:0] instr_in,
    output logic [NB_ADDR-1:0]  pc_p1,
    output logic [NB_ADDR-1:0]  pc4_p1,
    output logic [NB_INSTR-1:0] instr_p1,
    output logic                vld_p1
);

    // IF -> ID boundary: capture, bubble, invalidate or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1    <= '0;
            pc4_p1   <= '0;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (flush) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (kill) begin
            vld_p1   <= 1'b0;
        end else if (load) begin
            pc_p1    <= pc_in;
            pc4_p1   <= pc4_in;
            instr_p1 <= instr_in;
            vld_p1   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, the RUN/TRAP fetch FSM, the fault
// bookkeeping and the fetch counter, and feeds the IF/ID register.
module if_stage
    import riscv_defs::*;
#(
    parameter logic [NB_ADDR-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                 MEM_BYTES = MEM_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    imem_if.cpu                 imem,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [NB_ADDR-1:0]  target_i,
    output logic [NB_ADDR-1:0]  ifid_pc_o,
    output logic [NB_ADDR-1:0]  ifid_pc4_o,
    output logic [NB_INSTR-1:0] ifid_instr_o,
    output logic                ifid_valid_o,
    output logic                trap_o,
    output logic [NB_ADDR-1:0]  trap_addr_o,
    output logic [31:0]         fetch_cnt_o
);

    // Highest address at which a whole word can still be fetched.
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_BYTES - 4);

    fetch_state_t       state_q;
    logic [NB_ADDR-1:0] pc_p0;
    logic [NB_ADDR-1:0] pc4_p0;
    logic [NB_ADDR-1:0] trap_addr_q;
    logic [31:0]        fetch_cnt_q;

    logic target_ok;
    logic pc_fault;
    logic do_load;
    logic do_flush;
    logic do_kill;

    // The PC register goes straight to the memory with nothing in between.
    assign imem.imem_pc = pc_p0;
    assign pc4_p0       = pc_p0 + 32'd4;

    assign target_ok = (target_i[1:0] == 2'b00) && (target_i <= LAST_ADDR);
    assign pc_fault  = (pc_p0 > LAST_ADDR);

    // IF/ID control: redirect first, then the PC fault, then stall, else advance
    always_comb begin
        do_load  = 1'b0;
        do_flush = 1'b0;
        do_kill  = 1'b0;
        if (state_q == RUN) begin
            if (redirect_i) begin
                if (target_ok) do_flush = 1'b1;
                else           do_kill  = 1'b1;
            end else if (pc_fault) begin
                do_kill = 1'b1;
            end else if (!stall_i) begin
                do_load = 1'b1;
            end
        end
    end

    // Fetch FSM with PC, trap address and fetch counter; TRAP is left only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_p0       <= RESET_PC;
            trap_addr_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect_i) begin
                        if (target_ok) begin
                            pc_p0 <= target_i;
                        end else begin
                            state_q     <= TRAP;
                            trap_addr_q <= target_i;
                        end
                    end else if (pc_fault) begin
                        state_q     <= TRAP;
                        trap_addr_q <= pc_p0;
                    end else if (!stall_i) begin
                        pc_p0       <= pc4_p0;
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                    end
                end
                TRAP: begin
                    state_q <= TRAP;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .flush    (do_flush),
        .kill     (do_kill),
        .pc_in    (pc_p0),
        .pc4_in   (pc4_p0),
        .instr_in (imem.imem_instruction),
        .pc_p1    (ifid_pc_o),
        .pc4_p1   (ifid_pc4_o),
        .instr_p1 (ifid_instr_o),
        .vld_p1   (ifid_valid_o)
    );

    assign trap_o      = (state_q == TRAP);
    assign trap_addr_o = trap_addr_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter MEM_BYTES, default MEM_SIZE (riscv_defs), instruction memory size in bytes.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 IMEM_IF  imem_if.cpu  --  drives imem_pc (32); receives imem_instruction (32), combinational, same cycle.
REQ-006 STALL_I  input  1  downstream hold; freeze PC and IF/ID register.
REQ-007 REDIRECT_I  input  1  taken branch/jump from EX; flush and load new PC.
REQ-008 TARGET_I  input  32  redirect address, qualified by REDIRECT_I.
REQ-009 IFID_PC_O  output  32  PC of latched instruction.
REQ-010 IFID_PC4_O  output  32  IFID_PC_O + 4, for link address.
REQ-011 IFID_INSTR_O  output  32  latched instruction word.
REQ-012 IFID_VALID_O  output  1  IF/ID contents are a real instruction.
REQ-013 TRAP_O  output  1  sticky fetch fault flag.
REQ-014 TRAP_ADDR_O  output  32  faulting fetch address.
REQ-015 FETCH_CNT_O  output  32  count of instructions latched into IF/ID.

Function
REQ-016 PC register SHALL drive imem_pc directly; no other logic on that path.
REQ-017 FSM SHALL have two states: RUN, TRAP; reset state RUN.
REQ-018 In RUN, per cycle, priority SHALL be: REDIRECT_I > fault check > STALL_I > normal advance.
REQ-019 Normal advance (RUN, no redirect, no stall, no fault): PC <= PC+4; IF/ID <= {PC, PC+4, imem_instruction}; VALID <= 1; FETCH_CNT += 1.
REQ-020 Stall: PC, IF/ID, VALID, FETCH_CNT SHALL hold.
REQ-021 Redirect with TARGET_I[1:0] == 0 and TARGET_I <= MEM_BYTES-4: PC <= TARGET_I; VALID <= 0; IFID_INSTR <= NOP_INSTR; applies even when STALL_I=1.
REQ-022 Redirect with TARGET_I[1:0] != 0 or TARGET_I > MEM_BYTES-4: go to TRAP; TRAP_ADDR <= TARGET_I; VALID <= 0; PC holds.
REQ-023 Fault check: PC > MEM_BYTES-4 in RUN without redirect SHALL enter TRAP with TRAP_ADDR <= PC, VALID <= 0, no counter increment, regardless of STALL_I.
REQ-024 TRAP_O SHALL be 1 exactly when state is TRAP.
REQ-025 In TRAP, PC, IF/ID, TRAP_ADDR, FETCH_CNT SHALL hold, VALID stays 0, REDIRECT_I and STALL_I are ignored; only RST exits.
REQ-026 Adders SHALL be 32-bit modulo 2^32; FETCH_CNT SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-027 Latency: instruction at PC appears on IFID_* one cycle after PC is presented.

Reset
REQ-028 With RST=1 at a clock edge: PC <= RESET_PC; IFID_PC_O, IFID_PC4_O <= 0; IFID_INSTR_O <= NOP_INSTR; VALID <= 0; state <= RUN; TRAP_ADDR <= 0; FETCH_CNT <= 0.
REQ-029 RST SHALL override stall, redirect and TRAP in the same cycle.
REQ-030 First valid IF/ID entry SHALL be RESET_PC, on the second edge after RST deasserts.

Structure
REQ-031 riscv_defs SHALL gain NB_ADDR=32, NB_INSTR=32, NOP_INSTR=32'h0000_0013 and the fetch FSM state enum.
REQ-032 MEM_SIZE, NB_BYTE and mem_t SHALL stay in riscv_defs and be reused.
REQ-033 Sub-module if_id_reg (IF/ID register with hold/flush/valid) SHALL be used; PC logic and FSM stay in if_stage.

Verification
REQ-034 Reset, run 4 cycles, memory words 0x00500093, 0x00100113, ... -> IFID_PC 0,4,8 with matching instructions, VALID=1, FETCH_CNT=3.
REQ-035 STALL_I=1 for 3 cycles at PC=8 -> IFID_PC stays 4, imem_pc stays 8, FETCH_CNT unchanged; release -> resumes at 8.
REQ-036 REDIRECT_I=1, TARGET_I=0x40, STALL_I=1 same cycle -> next cycle VALID=0, INSTR=0x00000013, imem_pc=0x40; following cycle IFID_PC=0x40.
REQ-037 REDIRECT_I=1, TARGET_I=0x42 -> TRAP_O=1, TRAP_ADDR=0x42, VALID=0; later redirects ignored; RST returns PC to RESET_PC, TRAP_O=0.
REQ-038 Sequential fetch up to PC=MEM_BYTES-4 then one more -> last word latched VALID=1, then TRAP_O=1, TRAP_ADDR=MEM_BYTES.
